long_division_axi4s_requester: RTL

- Initiator-side AXI4-S master for the long-division AXI4-S wrapper.
- Accepts a parallel dividend/divisor request from a client and serializes it into the two-beat ingress packet: beat 0 is the dividend with tlast=0; beat 1 is the divisor with tlast=1.
- Tags each packet with a rolling transaction ID and waits for the single-beat result carrying the same ID.
- Returns the quotient, overflow and an error flag to the client over a valid/ready handshake; a timeout guarantees forward progress.

---
 rtl/long_division_axi4s_requester.sv | 126 ++++++++++++
 1 files changed

// File: rtl/long_division_axi4s_requester.sv
// Client-side AXI4-S master for the long-division wrapper: serializes one
// dividend/divisor request into a two-beat packet and waits for its tagged result.
module long_division_axi4s_requester #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int N_BITS_P         = 32,
  parameter int TIMEOUT_P        = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [N_BITS_P-1:0]         req_dividend,
  input  logic [N_BITS_P-1:0]         req_divisor,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [N_BITS_P-1:0]         rsp_quotient,
  output logic                        rsp_overflow,
  output logic                        rsp_error,
  output logic                        div_tvalid,
  input  logic                        div_tready,
  output logic [AXI_DATA_WIDTH_P-1:0] div_tdata,
  output logic                        div_tlast,
  output logic [AXI_ID_WIDTH_P-1:0]   div_tid,
  input  logic                        res_tvalid,
  input  logic [AXI_DATA_WIDTH_P-1:0] res_tdata,
  input  logic                        res_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0]   res_tid,
  input  logic                        res_tuser,
  output logic                        stray_pulse
);
  localparam int TW = $clog2(TIMEOUT_P + 1);

  typedef enum logic [2:0] {IDLE, SEND_DIVIDEND, SEND_DIVISOR, WAIT_RESULT, RESPOND} state_t;
  state_t state, state_nxt;

  logic [N_BITS_P-1:0]       dividend_q, divisor_q, quot_q;
  logic                      ovf_q, err_q;
  logic [AXI_ID_WIDTH_P-1:0] id_cnt, tid_q;
  logic [TW-1:0]             tmo_cnt;
  logic                      match, tmo_hit;
  logic                      unused_res;

  // tlast is always 1 on the result channel and upper tdata bits carry nothing
  assign unused_res = ^{res_tlast, res_tdata};

  assign match   = (state == WAIT_RESULT) && res_tvalid && (res_tid == tid_q);
  assign tmo_hit = (state == WAIT_RESULT) && (tmo_cnt == TW'(TIMEOUT_P - 1));

  assign div_tid      = tid_q;
  assign rsp_quotient = quot_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      id_cnt     <= '0;
      tid_q      <= '0;
      tmo_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          dividend_q <= req_dividend;
          divisor_q  <= req_divisor;
          tid_q      <= id_cnt;
          id_cnt     <= id_cnt + 1'b1;
        end
        SEND_DIVISOR: if (div_tready) tmo_cnt <= '0;
        WAIT_RESULT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // a match arriving on the timeout cycle still wins
          if (match) begin
            quot_q <= res_tdata[N_BITS_P-1:0];
            ovf_q  <= res_tuser;
            err_q  <= 1'b0;
          end else if (tmo_hit) begin
            quot_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    div_tvalid  = 1'b0;
    div_tdata   = '0;
    div_tlast   = 1'b0;
    stray_pulse = res_tvalid && !match;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SEND_DIVIDEND;
      end
      SEND_DIVIDEND: begin
        div_tvalid = 1'b1;
        div_tdata  = AXI_DATA_WIDTH_P'(dividend_q);
        if (div_tready) state_nxt = SEND_DIVISOR;
      end
      SEND_DIVISOR: begin
        div_tvalid = 1'b1;
        div_tdata  = AXI_DATA_WIDTH_P'(divisor_q);
        div_tlast  = 1'b1;
        if (div_tready) state_nxt = WAIT_RESULT;
      end
      WAIT_RESULT: if (match || tmo_hit) state_nxt = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
